// File: rtl/ysyx_22050078_ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050078_ifu_pkg                                                |
// | Shared widths, reset constants and IFU state encodings.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ysyx_22050078_ifu_pkg;

  localparam int CPU_WIDTH  = 64;
  localparam int INST_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0]  RESET_PC = 64'h8000_0000;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_AR  = 2'd0,
    S_R   = 2'd1,
    S_OUT = 2'd2
  } ifu_state_e;

  // The 64-bit bus returns two instruction words; PC bit 2 picks one.
  function automatic logic [INST_WIDTH-1:0] sel_word(input logic [CPU_WIDTH-1:0] data,
                                                     input logic                 hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050078_ifu_stdreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050078_ifu_stdreg                                             |
// | Write-enabled register with synchronous reset to a constant.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_22050078_ifu_stdreg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= RESET_VAL;
    end else if (i_wen) begin
      dout_q <= i_din;
    end
  end

  assign o_dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050078_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050078_ifu                                                    |
// | Single-outstanding instruction fetch: AR -> R -> OUT handshake FSM.  |
// | Option: YSYX_22050078_IFU_MISALIGN_CHK_EN adds misaligned-PC flag.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_22050078_ifu
  import ysyx_22050078_ifu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CPU_WIDTH-1:0]  i_pc,
  input  logic                  i_flush,
  output logic                  o_pc_adv,
  output logic                  o_ar_valid,
  output logic [CPU_WIDTH-1:0]  o_ar_addr,
  input  logic                  i_ar_ready,
  input  logic                  i_r_valid,
  input  logic [CPU_WIDTH-1:0]  i_r_data,
  output logic                  o_r_ready,
  output logic                  o_inst_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [CPU_WIDTH-1:0]  o_inst_pc,
  input  logic                  i_inst_ready
`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
  ,
  output logic                  o_inst_misalign
`endif
);

  ifu_state_e            state_q;
  logic                  pend_q;
  logic                  kill_q;
  logic [CPU_WIDTH-1:0]  fpc_q;
  logic [INST_WIDTH-1:0] inst_d;
  logic                  in_ar;
  logic                  misal;
  logic                  misal_take;
  logic                  fpc_we;
  logic                  inst_we;
  logic                  drop;

  assign in_ar = (state_q == S_AR) & ~rst;

`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
  assign misal = in_ar & ~pend_q & (i_pc[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  assign misal_take = misal & ~i_flush;

  // Once presented, the address comes from the latched fetch PC so it
  // cannot move under a redirect before the memory accepts it.
  assign o_ar_valid = in_ar & ~misal;
  assign o_ar_addr  = (pend_q ? fpc_q : i_pc) & ~64'h7;
  assign o_r_ready  = (state_q == S_R);

  assign o_inst_valid = (state_q == S_OUT);
  assign o_pc_adv     = o_inst_valid & i_inst_ready & ~i_flush;
  assign o_inst_pc    = fpc_q;

  assign drop    = kill_q | i_flush;
  assign fpc_we  = in_ar & ~pend_q;
  assign inst_we = (o_r_ready & i_r_valid & ~drop) | misal_take;
  assign inst_d  = misal_take ? '0 : sel_word(i_r_data, fpc_q[2]);

  ysyx_22050078_ifu_stdreg #(
    .WIDTH     (CPU_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_fpc_reg (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (fpc_we),
    .i_din  (i_pc),
    .o_dout (fpc_q)
  );

  ysyx_22050078_ifu_stdreg #(
    .WIDTH     (INST_WIDTH),
    .RESET_VAL (NOP_INST)
  ) u_inst_reg (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (inst_we),
    .i_din  (inst_d),
    .o_dout (o_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_AR;
      pend_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_AR: begin
          if (misal_take) begin
            state_q <= S_OUT;
          end else if (o_ar_valid) begin
            // A presented request cannot be withdrawn; mark it for discard.
            if (i_flush) begin
              kill_q <= 1'b1;
            end
            if (i_ar_ready) begin
              state_q <= S_R;
              pend_q  <= 1'b0;
            end else begin
              pend_q  <= 1'b1;
            end
          end
        end
        S_R: begin
          if (i_flush) begin
            kill_q <= 1'b1;
          end
          if (i_r_valid) begin
            kill_q  <= 1'b0;
            state_q <= drop ? S_AR : S_OUT;
          end
        end
        S_OUT: begin
          if (i_flush || i_inst_ready) begin
            state_q <= S_AR;
          end
        end
        default: begin
          state_q <= S_AR;
        end
      endcase
    end
  end

`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (inst_we) begin
      mis_q <= misal_take;
    end
  end

  assign o_inst_misalign = mis_q & o_inst_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050078_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_22050078_ifu                                                 |
// | Scoreboard bench: directed fetch/flush/stall scenarios for the IFU.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ysyx_22050078_ifu;

  logic        clk;
  logic        rst;
  logic [63:0] i_pc;
  logic        i_flush;
  logic        o_pc_adv;
  logic        o_ar_valid;
  logic [63:0] o_ar_addr;
  logic        i_ar_ready;
  logic        i_r_valid;
  logic [63:0] i_r_data;
  logic        o_r_ready;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [63:0] o_inst_pc;
  logic        i_inst_ready;
`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
  logic        o_inst_misalign;
`endif

  ysyx_22050078_ifu u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_pc         (i_pc),
    .i_flush      (i_flush),
    .o_pc_adv     (o_pc_adv),
    .o_ar_valid   (o_ar_valid),
    .o_ar_addr    (o_ar_addr),
    .i_ar_ready   (i_ar_ready),
    .i_r_valid    (i_r_valid),
    .i_r_data     (i_r_data),
    .o_r_ready    (o_r_ready),
    .o_inst_valid (o_inst_valid),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .i_inst_ready (i_inst_ready)
`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
    ,
    .o_inst_misalign (o_inst_misalign)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_addr_q[$];

  int n_chk;
  int n_fail;
  int acc_cnt;
  int adv_cnt;
  int cyc;
  int last_acc_cyc;
  int prev_acc_cyc;
  int ar_dly;
  int r_dly;
  logic        redir_req;
  logic [63:0] redir_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 64'h0020_0113_0010_0093;
      64'h8000_0008: return 64'h0040_0213_0030_0193;
      default:       return 64'hDEAD_BEEF_0010_0093;
    endcase
  endfunction

  task automatic wait_acc(input int n);
    int t;
    t = 0;
    while (acc_cnt < n && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (acc_cnt < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_acc: accepted %0d required %0d", acc_cnt, n);
    end
  endtask

  // Memory responder: one request at a time, programmable wait states.
  initial begin : mem_model
    logic [63:0] a0;
    int          rd;
    i_ar_ready = 1'b0;
    i_r_valid  = 1'b0;
    i_r_data   = '0;
    forever begin
      @(negedge clk);
      if (o_ar_valid) begin
        a0 = o_ar_addr;
        if (exp_addr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ar_addr_unexpected: got %h expected none", a0);
        end else begin
          chk("ar_addr", a0, exp_addr_q.pop_front());
        end
        for (int k = 0; k < ar_dly; k++) begin
          @(negedge clk);
          chk("ar_addr_stable", o_ar_addr, a0);
          chk("ar_valid_stable", {63'd0, o_ar_valid}, 64'd1);
        end
        i_ar_ready = 1'b1;
        @(posedge clk); #1;
        i_ar_ready = 1'b0;
        rd = r_dly;
        repeat (rd) begin
          @(posedge clk); #1;
        end
        i_r_valid = 1'b1;
        i_r_data  = mem_rd(a0);
        @(posedge clk); #1;
        i_r_valid = 1'b0;
      end
    end
  end

  // PC unit: loads PC+4 on the advance strobe, or a redirect target.
  initial begin : pc_unit
    logic adv;
    i_pc      = 64'h8000_0000;
    redir_req = 1'b0;
    redir_pc  = '0;
    forever begin
      @(negedge clk);
      adv = o_pc_adv;
      @(posedge clk); #1;
      if (redir_req) begin
        i_pc      = redir_pc;
        redir_req = 1'b0;
      end else if (adv) begin
        i_pc = i_pc + 64'd4;
      end
    end
  end

  // Monitor: every accepted instruction is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_pc_adv) adv_cnt++;
      if (o_inst_valid && i_inst_ready && !i_flush) begin
        acc_cnt++;
        prev_acc_cyc = last_acc_cyc;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL inst_unexpected: got %h expected none", o_inst);
        end else begin
          e = exp_q.pop_front();
          chk("inst", {32'd0, o_inst}, {32'd0, e.inst});
          chk("inst_pc", o_inst_pc, e.pc);
          chk("pc_adv_on_accept", {63'd0, o_pc_adv}, 64'd1);
`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
          chk("inst_misalign", {63'd0, o_inst_misalign}, {63'd0, e.mis});
`endif
        end
      end else if (o_pc_adv) begin
        chk("pc_adv_spurious", {63'd0, o_pc_adv}, 64'd0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stimulus
    int t;
    rst          = 1'b1;
    i_flush      = 1'b0;
    i_inst_ready = 1'b1;
    ar_dly       = 0;
    r_dly        = 0;

    exp_q.push_back('{32'h0010_0093, 64'h8000_0000, 1'b0});
    exp_q.push_back('{32'h0020_0113, 64'h8000_0004, 1'b0});
    exp_q.push_back('{32'h0030_0193, 64'h8000_0008, 1'b0});
    exp_q.push_back('{32'hDEAD_BEEF, 64'h8000_0024, 1'b0});
    exp_q.push_back('{32'h0010_0093, 64'h8000_0028, 1'b0});
`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
    exp_q.push_back('{32'h0000_0000, 64'h8000_0002, 1'b1});
`endif
    foreach (exp_addr_q[i]) exp_addr_q.delete(i);
    exp_addr_q.push_back(64'h8000_0000);
    exp_addr_q.push_back(64'h8000_0000);
    exp_addr_q.push_back(64'h8000_0008);
    exp_addr_q.push_back(64'h8000_0008);
    exp_addr_q.push_back(64'h8000_0010);
    exp_addr_q.push_back(64'h8000_0020);
    exp_addr_q.push_back(64'h8000_0028);
    exp_addr_q.push_back(64'h8000_0028);
    exp_addr_q.push_back(64'h8000_0028);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_valid", {63'd0, o_ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, o_r_ready}, 64'd0);
    chk("rst_inst_valid", {63'd0, o_inst_valid}, 64'd0);
    chk("rst_pc_adv", {63'd0, o_pc_adv}, 64'd0);
    chk("rst_inst", {32'd0, o_inst}, 64'h0000_0013);
    chk("rst_inst_pc", o_inst_pc, 64'h8000_0000);
`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
    chk("rst_misalign", {63'd0, o_inst_misalign}, 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ar_valid_after_rst", {63'd0, o_ar_valid}, 64'd1);

    // Zero-wait back-to-back fetch of both words of one doubleword
    wait_acc(2);
    chk("adv_spacing", 64'(last_acc_cyc - prev_acc_cyc), 64'd3);

    // Memory wait states, then decode stall in S_OUT
    ar_dly       = 3;
    r_dly        = 2;
    i_inst_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!o_inst_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ar_to_inst_latency", 64'(t), 64'd7);
    for (int k = 0; k < 4; k++) begin
      chk("stall_inst", {32'd0, o_inst}, 64'h0030_0193);
      chk("stall_inst_pc", o_inst_pc, 64'h8000_0008);
      chk("stall_no_adv", {63'd0, o_pc_adv}, 64'd0);
      if (k < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    i_inst_ready = 1'b1;
    ar_dly       = 0;
    r_dly        = 0;
    wait_acc(3);
    chk("adv_pulse_count", 64'(adv_cnt), 64'd3);

    // Flush while the request is on the AR channel, then flush in S_R
    i_flush = 1'b1;
    @(negedge clk);
    redir_pc  = 64'h8000_0010;
    redir_req = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(posedge clk); #1;
    r_dly = 1;
    @(negedge clk);
    chk("kill_ar_no_valid", {63'd0, o_inst_valid}, 64'd0);
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush_in_r_state", {63'd0, o_r_ready}, 64'd1);
    redir_pc  = 64'h8000_0024;
    redir_req = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    r_dly   = 0;
    @(negedge clk);
    chk("kill_r_no_valid", {63'd0, o_inst_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("kill_r_no_valid2", {63'd0, o_inst_valid}, 64'd0);
    chk("refetch_ar_valid", {63'd0, o_ar_valid}, 64'd1);
    chk("refetch_ar_addr", o_ar_addr, 64'h8000_0020);
    wait_acc(4);

    // Flush and ready together in S_OUT: flush wins
    t = 0;
    @(posedge clk); #1;
    while (!o_inst_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_valid", {63'd0, o_inst_valid}, 64'd1);
    chk("flush_ready_no_adv", {63'd0, o_pc_adv}, 64'd0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_out_drop_valid", {63'd0, o_inst_valid}, 64'd0);
    chk("flush_out_to_ar", {63'd0, o_ar_valid}, 64'd1);
    chk("flush_out_ar_addr", o_ar_addr, 64'h8000_0028);
    wait_acc(5);
    i_inst_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("held_valid", {63'd0, o_inst_valid}, 64'd1);

`ifdef YSYX_22050078_IFU_MISALIGN_CHK_EN
    // Misaligned redirect target: no bus read, flagged instruction
    i_flush = 1'b1;
    @(negedge clk);
    redir_pc  = 64'h8000_0002;
    redir_req = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("misal_no_ar_valid", {63'd0, o_ar_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("misal_valid", {63'd0, o_inst_valid}, 64'd1);
    chk("misal_flag", {63'd0, o_inst_misalign}, 64'd1);
    chk("misal_inst", {32'd0, o_inst}, 64'd0);
    chk("misal_pc", o_inst_pc, 64'h8000_0002);
    @(posedge clk); #1;
    i_inst_ready = 1'b1;
    @(posedge clk); #1;
    i_inst_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`endif

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
